// File: rtl/label_vote_filter_if.sv
// Sample/result handshake bundle for label_vote_filter.
// master = upstream/downstream side, slave = the filter.
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 10
`endif

interface label_vote_filter_if #(
   parameter int CW = 4
);
   logic                         ValidIn_SI;
   logic                         ReadyOut_SO;
   logic [`LABEL_WIDTH-1:0]      LabelIn_A_DI;
   logic [`LABEL_WIDTH-1:0]      LabelIn_V_DI;
   logic [`DISTANCE_WIDTH-1:0]   DistanceIn_A_DI;
   logic [`DISTANCE_WIDTH-1:0]   DistanceIn_V_DI;
   logic                         Clear_SI;
   logic                         ValidOut_SO;
   logic                         ReadyIn_SI;
   logic [`LABEL_WIDTH-1:0]      LabelOut_A_DO;
   logic [`LABEL_WIDTH-1:0]      LabelOut_V_DO;
   logic [CW-1:0]                Votes_A_DO;
   logic [CW-1:0]                Votes_V_DO;
   logic [CW-1:0]                Fill_A_DO;
   logic [CW-1:0]                Fill_V_DO;
   logic                         Reject_A_DO;
   logic                         Reject_V_DO;

   modport master (
      output ValidIn_SI, LabelIn_A_DI, LabelIn_V_DI, DistanceIn_A_DI, DistanceIn_V_DI,
             Clear_SI, ReadyIn_SI,
      input  ReadyOut_SO, ValidOut_SO, LabelOut_A_DO, LabelOut_V_DO, Votes_A_DO, Votes_V_DO,
             Fill_A_DO, Fill_V_DO, Reject_A_DO, Reject_V_DO
   );

   modport slave (
      input  ValidIn_SI, LabelIn_A_DI, LabelIn_V_DI, DistanceIn_A_DI, DistanceIn_V_DI,
             Clear_SI, ReadyIn_SI,
      output ReadyOut_SO, ValidOut_SO, LabelOut_A_DO, LabelOut_V_DO, Votes_A_DO, Votes_V_DO,
             Fill_A_DO, Fill_V_DO, Reject_A_DO, Reject_V_DO
   );
endinterface

// File: rtl/label_vote_filter.sv
// Majority-vote smoothing of binary arousal/valence labels over a sliding window,
// with per-channel distance gating of unreliable samples.
//
// state         | meaning
// S_IDLE        | ready; capture a sample or apply a history clear
// S_UPDATE      | gate, shift history, recount votes, decide labels
// S_OUT_STABLE  | result valid and held until downstream ready
`ifndef LABEL_WIDTH
`define LABEL_WIDTH 4
`endif
`ifndef DISTANCE_WIDTH
`define DISTANCE_WIDTH 10
`endif

module label_vote_filter #(
   parameter int                          WINDOW      = 8,
   parameter logic [`DISTANCE_WIDTH-1:0]  DIST_THRESH = {`DISTANCE_WIDTH{1'b1}},
   parameter int                          CW          = $clog2(WINDOW + 1)
) (
   input  logic                 Clk_CI,
   input  logic                 Reset_RBI,
   label_vote_filter_if.slave   bus
);
   localparam int LW = `LABEL_WIDTH;
   localparam int DW = `DISTANCE_WIDTH;
   localparam logic [CW-1:0] L_WIN = CW'(WINDOW);

   localparam logic [1:0] S_IDLE       = 2'd0;
   localparam logic [1:0] S_UPDATE     = 2'd1;
   localparam logic [1:0] S_OUT_STABLE = 2'd2;

   // channel index 0 = arousal (A), 1 = valence (V)
   logic [1:0]        r_state;
   logic [WINDOW-1:0] r_hist     [2];
   logic [CW-1:0]     r_votes    [2];
   logic [CW-1:0]     r_fill     [2];
   logic              r_lab      [2];
   logic              r_rej      [2];
   logic              r_cap_lab  [2];
   logic [DW-1:0]     r_cap_dist [2];

   logic              w_acc      [2];
   logic              w_full     [2];
   logic              w_evict    [2];
   logic [CW-1:0]     w_votes_n  [2];
   logic [CW-1:0]     w_fill_n   [2];
   logic [CW-1:0]     w_o        [2];
   logic [CW-1:0]     w_f        [2];
   logic              w_lab_n    [2];
   logic [WINDOW-1:0] w_hist_n   [2];
   logic              w_unused_bits;

   // Newest entry sits at bit 0; once full, bit WINDOW-1 is the one evicted.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         w_acc[c]     = (r_cap_dist[c] <= DIST_THRESH);
         w_full[c]    = (r_fill[c] == L_WIN);
         w_evict[c]   = w_full[c] & r_hist[c][WINDOW-1];
         w_hist_n[c]  = {r_hist[c][WINDOW-2:0], r_cap_lab[c]};
         w_votes_n[c] = r_votes[c] + CW'(r_cap_lab[c]) - CW'(w_evict[c]);
         w_fill_n[c]  = w_full[c] ? r_fill[c] : r_fill[c] + CW'(1);
         w_o[c]       = w_acc[c] ? w_votes_n[c] : r_votes[c];
         w_f[c]       = w_acc[c] ? w_fill_n[c]  : r_fill[c];
         w_lab_n[c]   = r_lab[c];
         if (w_f[c] != '0) begin
            if ({w_o[c], 1'b0} > {1'b0, w_f[c]})
               w_lab_n[c] = 1'b1;
            else if ({w_o[c], 1'b0} < {1'b0, w_f[c]})
               w_lab_n[c] = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         r_state <= S_IDLE;
         for (int c = 0; c < 2; c++) begin
            r_hist[c]     <= '0;
            r_votes[c]    <= '0;
            r_fill[c]     <= '0;
            r_lab[c]      <= 1'b0;
            r_rej[c]      <= 1'b0;
            r_cap_lab[c]  <= 1'b0;
            r_cap_dist[c] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.Clear_SI) begin
                  for (int c = 0; c < 2; c++) begin
                     r_hist[c]  <= '0;
                     r_votes[c] <= '0;
                     r_fill[c]  <= '0;
                     r_lab[c]   <= 1'b0;
                  end
               end else if (bus.ValidIn_SI) begin
                  r_cap_lab[0]  <= bus.LabelIn_A_DI[0];
                  r_cap_lab[1]  <= bus.LabelIn_V_DI[0];
                  r_cap_dist[0] <= bus.DistanceIn_A_DI;
                  r_cap_dist[1] <= bus.DistanceIn_V_DI;
                  r_state       <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               for (int c = 0; c < 2; c++) begin
                  if (w_acc[c]) begin
                     r_hist[c]  <= w_hist_n[c];
                     r_votes[c] <= w_votes_n[c];
                     r_fill[c]  <= w_fill_n[c];
                  end
                  r_rej[c] <= ~w_acc[c];
                  r_lab[c] <= w_lab_n[c];
               end
               r_state <= S_OUT_STABLE;
            end
            S_OUT_STABLE: begin
               if (bus.ReadyIn_SI)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Only bit 0 of each label votes (two classes).
   assign w_unused_bits = ^{bus.LabelIn_A_DI[LW-1:1], bus.LabelIn_V_DI[LW-1:1]};

   assign bus.ReadyOut_SO   = (r_state == S_IDLE) && !bus.Clear_SI;
   assign bus.ValidOut_SO   = (r_state == S_OUT_STABLE);
   assign bus.LabelOut_A_DO = {{(LW-1){1'b0}}, r_lab[0]};
   assign bus.LabelOut_V_DO = {{(LW-1){1'b0}}, r_lab[1]};
   assign bus.Votes_A_DO    = r_votes[0];
   assign bus.Votes_V_DO    = r_votes[1];
   assign bus.Fill_A_DO     = r_fill[0];
   assign bus.Fill_V_DO     = r_fill[1];
   assign bus.Reject_A_DO   = r_rej[0];
   assign bus.Reject_V_DO   = r_rej[1];
endmodule

// File: tb/tb_label_vote_filter.sv
// Directed bench for label_vote_filter, WINDOW=8, DIST_THRESH=400.
module tb_label_vote_filter;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   logic e_la, e_lv, e_ra, e_rv;
   int   e_va, e_fa, e_vv, e_fv;

   always #5 clk = ~clk;

   label_vote_filter_if #(.CW(4)) bus ();

   label_vote_filter #(
      .WINDOW      (8),
      .DIST_THRESH (10'd400)
   ) dut (
      .Clk_CI    (clk),
      .Reset_RBI (rst_n),
      .bus       (bus)
   );

   task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_outs(input string where);
      check_val({where, "_label_a"},  bus.LabelOut_A_DO, {3'b000, e_la});
      check_val({where, "_votes_a"},  bus.Votes_A_DO,    e_va);
      check_val({where, "_fill_a"},   bus.Fill_A_DO,     e_fa);
      check_val({where, "_reject_a"}, bus.Reject_A_DO,   e_ra);
      check_val({where, "_label_v"},  bus.LabelOut_V_DO, {3'b000, e_lv});
      check_val({where, "_votes_v"},  bus.Votes_V_DO,    e_vv);
      check_val({where, "_fill_v"},   bus.Fill_V_DO,     e_fv);
      check_val({where, "_reject_v"}, bus.Reject_V_DO,   e_rv);
   endtask

   task automatic send(input logic la, input int da, input logic lv, input int dv,
                       input int hold, input bit do_chk);
      int n = 0;
      @(negedge clk);
      while (!bus.ReadyOut_SO && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("ready_idle", bus.ReadyOut_SO, 1);
      bus.LabelIn_A_DI    = 4'(la);
      bus.LabelIn_V_DI    = 4'(lv);
      bus.DistanceIn_A_DI = 10'(da);
      bus.DistanceIn_V_DI = 10'(dv);
      bus.ValidIn_SI      = 1'b1;
      bus.ReadyIn_SI      = 1'b0;
      @(negedge clk);
      bus.ValidIn_SI = 1'b0;
      check_val("vout_update", bus.ValidOut_SO, 0);
      @(negedge clk);
      check_val("vout_t2", bus.ValidOut_SO, 1);
      check_val("ready_busy", bus.ReadyOut_SO, 0);
      if (do_chk) check_outs("stable");
      for (int i = 0; i < hold; i++) begin
         bus.ValidIn_SI      = ~i[0];
         bus.LabelIn_A_DI    = 4'(~la);
         bus.LabelIn_V_DI    = 4'(~lv);
         bus.DistanceIn_A_DI = 10'd0;
         bus.DistanceIn_V_DI = 10'd0;
         @(negedge clk);
         check_val("hold_vout", bus.ValidOut_SO, 1);
         check_val("hold_ready", bus.ReadyOut_SO, 0);
         if (do_chk) check_outs("hold");
      end
      bus.ValidIn_SI = 1'b0;
      bus.ReadyIn_SI = 1'b1;
      @(negedge clk);
      bus.ReadyIn_SI = 1'b0;
      check_val("vout_drop", bus.ValidOut_SO, 0);
      if (do_chk) check_outs("retain");
   endtask

   initial begin
      bus.ValidIn_SI      = 1'b0;
      bus.ReadyIn_SI      = 1'b0;
      bus.Clear_SI        = 1'b0;
      bus.LabelIn_A_DI    = '0;
      bus.LabelIn_V_DI    = '0;
      bus.DistanceIn_A_DI = '0;
      bus.DistanceIn_V_DI = '0;

      repeat (2) @(negedge clk);
      check_val("rst_vout",   bus.ValidOut_SO, 0);
      check_val("rst_ready",  bus.ReadyOut_SO, 1);
      check_val("rst_fill_a", bus.Fill_A_DO, 0);
      check_val("rst_votes_a", bus.Votes_A_DO, 0);
      rst_n = 1'b1;

      // single sample
      e_la = 1; e_va = 1; e_fa = 1; e_ra = 0;
      e_lv = 0; e_vv = 0; e_fv = 1; e_rv = 0;
      send(1'b1, 100, 1'b0, 100, 0, 1'b1);

      // ten ones then zeros: majority, tie hold, flip
      repeat (9) send(1'b1, 100, 1'b0, 100, 0, 1'b0);
      repeat (2) send(1'b0, 100, 1'b0, 100, 0, 1'b0);
      e_la = 1; e_va = 5; e_fa = 8; e_lv = 0; e_vv = 0; e_fv = 8;
      send(1'b0, 100, 1'b0, 100, 0, 1'b1);
      e_va = 4;
      send(1'b0, 100, 1'b0, 100, 0, 1'b1);
      e_va = 3; e_la = 0;
      send(1'b0, 100, 1'b0, 100, 0, 1'b1);

      // distance gating at the threshold boundary
      e_ra = 1; e_vv = 1; e_rv = 0;
      send(1'b1, 401, 1'b1, 400, 0, 1'b1);
      // an unchanged A history evicts a 1 here, keeping votes at 3
      e_ra = 0; e_va = 3; e_vv = 1;
      send(1'b1, 0, 1'b0, 0, 0, 1'b1);

      // downstream stall with ignored input pulses
      e_vv = 2;
      send(1'b1, 0, 1'b1, 0, 5, 1'b1);

      // clear and valid together
      @(negedge clk);
      bus.Clear_SI        = 1'b1;
      bus.ValidIn_SI      = 1'b1;
      bus.LabelIn_A_DI    = 4'd1;
      bus.LabelIn_V_DI    = 4'd1;
      bus.DistanceIn_A_DI = 10'd0;
      bus.DistanceIn_V_DI = 10'd0;
      #1;
      check_val("clr_ready", bus.ReadyOut_SO, 0);
      @(negedge clk);
      bus.Clear_SI   = 1'b0;
      bus.ValidIn_SI = 1'b0;
      check_val("clr_vout",    bus.ValidOut_SO, 0);
      check_val("clr_fill_a",  bus.Fill_A_DO, 0);
      check_val("clr_votes_a", bus.Votes_A_DO, 0);
      check_val("clr_fill_v",  bus.Fill_V_DO, 0);
      check_val("clr_votes_v", bus.Votes_V_DO, 0);
      @(negedge clk);
      check_val("clr_vout2",  bus.ValidOut_SO, 0);
      check_val("clr_ready2", bus.ReadyOut_SO, 1);
      e_la = 1; e_va = 1; e_fa = 1; e_ra = 0;
      e_lv = 1; e_vv = 1; e_fv = 1; e_rv = 0;
      send(1'b1, 0, 1'b1, 0, 0, 1'b1);

      // reset during UPDATE
      @(negedge clk);
      bus.LabelIn_A_DI = 4'd1;
      bus.LabelIn_V_DI = 4'd1;
      bus.ValidIn_SI   = 1'b1;
      @(negedge clk);
      bus.ValidIn_SI = 1'b0;
      rst_n = 1'b0;
      #1;
      check_val("arst_vout",    bus.ValidOut_SO, 0);
      check_val("arst_fill_a",  bus.Fill_A_DO, 0);
      check_val("arst_votes_a", bus.Votes_A_DO, 0);
      check_val("arst_label_a", bus.LabelOut_A_DO, 0);
      check_val("arst_fill_v",  bus.Fill_V_DO, 0);
      check_val("arst_votes_v", bus.Votes_V_DO, 0);
      check_val("arst_label_v", bus.LabelOut_V_DO, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_val("arst_ready", bus.ReadyOut_SO, 1);
      check_val("arst_vout2", bus.ValidOut_SO, 0);
      @(negedge clk);
      check_val("arst_vout3", bus.ValidOut_SO, 0);
      e_la = 0; e_va = 0; e_fa = 1; e_ra = 0;
      e_lv = 1; e_vv = 1; e_fv = 1; e_rv = 0;
      send(1'b0, 0, 1'b1, 0, 0, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/label_vote_filter.md
LABEL_VOTE_FILTER -- requirements
Module: label_vote_filter

Interface
REQ-001 Parameter WINDOW, 8, history depth per channel (arousal A, valence V); legal range 2..16.
REQ-002 Parameter DIST_THRESH, {`DISTANCE_WIDTH{1'b1}}, maximum accepted distance; samples above it are rejected.
REQ-003 Parameter CW, ceilLog2(WINDOW+1), width of vote and fill counts.
REQ-004 Clk_CI  in  1  sole clock, rising edge.
REQ-005 Reset_RBI  in  1  reset, asynchronous assert, active-low.
REQ-006 ValidIn_SI  in  1  upstream sample valid; this is the associative-memory output valid.
REQ-007 ReadyOut_SO  out  1  block can accept a sample.
REQ-008 LabelIn_A_DI, LabelIn_V_DI  in  `LABEL_WIDTH each  class labels; only bit 0 votes (CLASSES==2).
REQ-009 DistanceIn_A_DI, DistanceIn_V_DI  in  `DISTANCE_WIDTH each  Hamming distances of the labels.
REQ-010 Clear_SI  in  1  synchronous history clear.
REQ-011 ValidOut_SO  out  1  result valid.
REQ-012 ReadyIn_SI  in  1  downstream ready.
REQ-013 LabelOut_A_DO, LabelOut_V_DO  out  `LABEL_WIDTH each  smoothed labels, upper bits 0.
REQ-014 Votes_A_DO, Votes_V_DO  out  CW each  count of label-1 entries in the history.
REQ-015 Fill_A_DO, Fill_V_DO  out  CW each  valid history entries, saturating at WINDOW.
REQ-016 Reject_A_DO, Reject_V_DO  out  1 each  the current sample was gated out.

Function
REQ-017 The FSM SHALL have states IDLE, UPDATE and OUTPUT_STABLE, and SHALL enter IDLE on reset.
REQ-018 IDLE: ReadyOut_SO=1 when Clear_SI=0, else 0.
REQ-019 IDLE with ValidIn_SI=1 and Clear_SI=0: labels and distances SHALL be captured, and the next state is UPDATE.
REQ-020 IDLE with Clear_SI=1: histories, votes, fills and output labels SHALL be set to 0, no sample is accepted, and the state stays IDLE.
REQ-021 Clear_SI SHALL be ignored outside IDLE.
REQ-022 UPDATE lasts exactly one cycle, then goes to OUTPUT_STABLE.
REQ-023 UPDATE SHALL process each channel independently: distance <= DIST_THRESH means accept (Reject=0); otherwise reject (Reject=1, history/votes/fill unchanged).
REQ-024 Accept SHALL shift label bit 0 into the newest history slot and evict the oldest slot when Fill==WINDOW.
REQ-025 Accept SHALL update Votes as Votes + new bit - evicted bit (the evicted term is 0 when not full), and SHALL increment Fill, saturating at WINDOW.
REQ-026 The decision SHALL use post-update values F=Fill and O=Votes: F==0 holds the previous label; 2*O>F gives 1; 2*O<F gives 0; 2*O==F holds the previous label.
REQ-027 All outputs SHALL be registered at the end of UPDATE and held stable through OUTPUT_STABLE.
REQ-028 OUTPUT_STABLE: ValidOut_SO=1 and ReadyOut_SO=0; ReadyIn_SI=1 returns to IDLE on that edge, else the state is held.
REQ-029 Latency: a sample accepted on edge t SHALL produce ValidOut_SO high from edge t+2; minimum initiation interval is 3 cycles.
REQ-030 ValidOut_SO and ReadyOut_SO SHALL never be high together.
REQ-031 Votes SHALL never exceed Fill, and Fill SHALL never exceed WINDOW; the counts have no wrap-around.
REQ-032 Outputs SHALL retain their values after the handshake until the next UPDATE or clear.

Reset
REQ-033 Reset_RBI low SHALL asynchronously zero all state: state=IDLE, histories, Votes, Fill, labels, Reject flags, and captured inputs.
REQ-034 Reset asserted mid-operation (UPDATE or OUTPUT_STABLE) SHALL abort the operation, drop ValidOut_SO immediately, and lose the pending result.
REQ-035 After deassertion, the first rising edge SHALL find ReadyOut_SO=1.

Verification (WINDOW=8, DIST_THRESH=400)
REQ-036 Single sample A=1/d=100, V=0/d=100, ReadyIn=1: ValidOut at t+2 with LabelA=1, VotesA=1, FillA=1, LabelV=0, VotesV=0, FillV=1, Rejects=0.
REQ-037 Ten A=1 samples then three A=0 samples: FillA=8, VotesA=5, LabelA=1; a fourth A=0 sample gives VotesA=4 (tie), LabelA held at 1; a fifth gives VotesA=3, LabelA=0.
REQ-038 A sample with distance 401 on A and 400 on V: RejectA=1 with A history unchanged; RejectV=0 with V accepted.
REQ-039 ReadyIn_SI held low 5 cycles in OUTPUT_STABLE: outputs stable, ValidOut high, and ValidIn pulses are ignored (ReadyOut=0).
REQ-040 Clear_SI and ValidIn_SI asserted together in IDLE: the sample is not accepted, all counts are 0, and the next sample yields Fill=1.
REQ-041 Reset_RBI pulsed low during UPDATE: ValidOut stays 0, all outputs are 0, and the FSM is in IDLE after release.
